adder_share_arbiter: RTL and testbench

//  Shares one scalar N-bit adder (add/sub with NZCV flags) between NREQ requesters, e.g. scalar ALU lanes and address generation.

---
 rtl/adder_arb_pkg.sv | 30 +++
 rtl/adder_nzcv.sv | 28 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/adder_share_arbiter.sv | 114 +++++++++++
 tb/tb_adder_share_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and widths for the shared-adder arbiter.
// Payload structs use the package widths; the top's DATA_W/NREQ defaults match them.
package adder_arb_pkg;

    localparam int unsigned ARB_DATA_W = 24;
    localparam int unsigned ARB_NREQ   = 4;
    localparam int unsigned ARB_ID_W   = $clog2(ARB_NREQ);
    localparam int unsigned FLAG_W     = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_DATA_W-1:0] a;
        logic [ARB_DATA_W-1:0] b;
        logic                  sub;
    } op_t;

    typedef struct packed {
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_DATA_W-1:0] r;
        flags_t                flags;
    } res_t;

endpackage

// File: rtl/adder_nzcv.sv
// N-bit add/sub with NZCV flags; subtract is A + ~B + 1.
module adder_nzcv
    import adder_arb_pkg::*;
#(
    parameter int unsigned N = 24
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] r,
    output flags_t       flags
);

    logic [N-1:0] b_eff;
    logic [N:0]   sum;

    always_comb begin
        b_eff   = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + (N+1)'(sub);
        r       = sum[N-1:0];
        flags.n = sum[N-1];
        flags.z = ~|sum[N-1:0];
        flags.c = sum[N];
        // Operands of equal effective sign producing a result of the other sign
        flags.v = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NREQ);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One add/sub unit shared round-robin between NREQ requesters, 2-stage pipeline.
// Optional ADDER_ARB_BACKPRESSURE_EN adds rsp_ready and stalls the pipeline on it.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned  DATA_W = ARB_DATA_W,
    parameter int unsigned  NREQ   = ARB_NREQ,
    localparam int unsigned ID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_r,
    output logic [FLAG_W-1:0]      rsp_flags
`ifdef ADDER_ARB_BACKPRESSURE_EN
    ,
    input  logic [NREQ-1:0]        rsp_ready
`endif
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_grant;
    logic              xfer;
    logic              op_valid;
    op_t               op_q;
    logic              res_valid;
    res_t              res_q;
    logic              res_stall;
    logic              res_adv;
    logic              op_adv;
    logic [DATA_W-1:0] add_r;
    flags_t            add_flags;
    flags_t            res_flags;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    adder_nzcv #(.N(DATA_W)) u_add (
        .a     (op_q.a),
        .b     (op_q.b),
        .sub   (op_q.sub),
        .r     (add_r),
        .flags (add_flags)
    );

    // Pipeline advance: result stage stalls only on backpressure, op stage when it cannot drain
    always_comb begin
`ifdef ADDER_ARB_BACKPRESSURE_EN
        res_stall = res_valid && !rsp_ready[res_q.id];
`else
        res_stall = 1'b0;
`endif
        res_adv   = !res_stall;
        op_adv    = !op_valid || res_adv;
        req_ready = grant & {NREQ{op_adv && !rst}};
        xfer      = any_grant && op_adv;
        ptr_nxt   = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Zero flag taken from the full-width result here rather than from the adder
    always_comb begin
        res_flags   = add_flags;
        res_flags.z = ~|add_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            op_valid  <= 1'b0;
            op_q      <= '0;
            res_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            if (op_adv) begin
                op_valid <= xfer;
                if (xfer) begin
                    op_q.id  <= grant_idx;
                    op_q.a   <= req_a[grant_idx*DATA_W +: DATA_W];
                    op_q.b   <= req_b[grant_idx*DATA_W +: DATA_W];
                    op_q.sub <= req_sub[grant_idx];
                end
            end
            if (xfer) begin
                ptr <= ptr_nxt;
            end
            if (res_adv) begin
                res_valid <= op_valid;
                if (op_valid) begin
                    res_q.id    <= op_q.id;
                    res_q.r     <= add_r;
                    res_q.flags <= res_flags;
                end
            end
        end
    end

    assign rsp_valid = res_valid ? (NREQ'(1) << res_q.id) : '0;
    assign rsp_r     = res_q.r;
    assign rsp_flags = res_q.flags;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter against a queue-based arithmetic model.
// Backpressure scenario is built only with ADDER_ARB_BACKPRESSURE_EN.
module tb_adder_share_arbiter;

    localparam int unsigned DW   = 24;
    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;
    localparam int unsigned CW   = NREQ + NREQ + DW + 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_r;
    logic [3:0]           rsp_flags;
`ifdef ADDER_ARB_BACKPRESSURE_EN
    logic [NREQ-1:0]      rsp_ready;
`endif

    int checks;
    int errors;

    typedef struct {
        int              due;
        logic [ID_W-1:0] id;
        logic [DW-1:0]   r;
        logic [3:0]      f;
    } exp_t;

    exp_t          q[$];
    int            m_ptr;
    int            edge_cnt;
    logic [DW-1:0] m_r;
    logic [3:0]    m_f;

    adder_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .rsp_flags (rsp_flags)
`ifdef ADDER_ARB_BACKPRESSURE_EN
        ,
        .rsp_ready (rsp_ready)
`endif
    );

    always #5 clk = ~clk;

    // Arithmetic reference from integer arithmetic on unsigned and signed views
    function automatic void ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic sub, output logic [DW-1:0] r,
                                    output logic [3:0] f);
        longint ua, ub, sa, sb, full, s, lim;
        ua  = longint'(64'(a));
        ub  = longint'(64'(b));
        lim = longint'(1) << (DW - 1);
        sa  = a[DW-1] ? ua - 2 * lim : ua;
        sb  = b[DW-1] ? ub - 2 * lim : ub;
        full = sub ? ua - ub : ua + ub;
        s    = sub ? sa - sb : sa + sb;
        r    = DW'(full);
        f[3] = r[DW-1];
        f[2] = (r == '0);
        f[1] = sub ? (ua >= ub) : (full >= 2 * lim);
        f[0] = (s >= lim) || (s < -lim);
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 24'h000000;
            1:       return 24'h7FFFFF;
            2:       return 24'h800000;
            3:       return 24'hFFFFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sub);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_sub[i]        = sub;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_r   = '0;
        m_f   = '0;
    endtask

    // One cycle from a negedge: observe grant, clock, observe response; returns DUT and model views
    task automatic step(output logic [CW-1:0] got, output logic [CW-1:0] exp);
        logic [NREQ-1:0] er, erv, gr;
        int              gi;
        exp_t            e;
        logic [ID_W-1:0] ix;
        #1;
        er  = '0;
        erv = '0;
        gi  = -1;
        if (!rst) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                ix = ID_W'((m_ptr + k) % NREQ);
                if (gi < 0 && req_valid[ix]) gi = int'(ix);
            end
        end
        gr = req_ready;
        if (gi >= 0) begin
            ix     = ID_W'(gi);
            er[ix] = 1'b1;
            e.due  = edge_cnt + 2;
            e.id   = ix;
            ref_alu(req_a[gi*DW +: DW], req_b[gi*DW +: DW], req_sub[ix], e.r, e.f);
            q.push_back(e);
            m_ptr = (gi + 1) % NREQ;
        end
        @(posedge clk);
        edge_cnt++;
        #1;
        if (q.size() > 0 && q[0].due == edge_cnt) begin
            e = q.pop_front();
            erv[e.id] = 1'b1;
            m_r = e.r;
            m_f = e.f;
        end
        got = {gr, rsp_valid, rsp_r, rsp_flags};
        exp = {er, erv, m_r, m_f};
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [CW-1:0] got, exp;
        @(negedge clk);
        model_reset();
        req_valid = '1;
        for (int i = 0; i < 2; i++) begin
            step(got, exp);
            checks++;
            if (got !== exp || got !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h exp %h", i, got, exp);
            end
        end
        rst       = 1'b0;
        req_valid = '0;
        step(got, exp);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h exp 0", got);
        end
    endtask

    task automatic test_arith();
        logic [CW-1:0] got, exp;
        logic [ID_W-1:0] id_t [5] = '{0, 2, 2, 1, 1};
        logic [DW-1:0]   a_t  [5] = '{24'h5, 24'h3, 24'h7, 24'h7FFFFF, 24'hFFFFFF};
        logic [DW-1:0]   b_t  [5] = '{24'h3, 24'h5, 24'h7, 24'h1, 24'h1};
        logic            s_t  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0]   r_t  [5] = '{24'h8, 24'hFFFFFE, 24'h0, 24'h800000, 24'h0};
        logic [3:0]      f_t  [5] = '{4'b0000, 4'b1000, 4'b0110, 4'b1001, 4'b0110};
        for (int i = 0; i < 5; i++) begin
            set_op(int'(id_t[i]), a_t[i], b_t[i], s_t[i]);
            req_valid = NREQ'(1) << id_t[i];
            for (int c = 0; c < 3; c++) begin
                step(got, exp);
                req_valid = '0;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL arith case %0d cyc %0d: got %h exp %h", i, c, got, exp);
                end
                if (c == 1) begin
                    checks++;
                    if ({rsp_valid, rsp_r, rsp_flags} !== {NREQ'(1) << id_t[i], r_t[i], f_t[i]}) begin
                        errors++;
                        $display("FAIL arith_const case %0d: got %b %h %b exp %b %h %b", i,
                                 rsp_valid, rsp_r, rsp_flags, NREQ'(1) << id_t[i], r_t[i], f_t[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] got, exp;
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < int'(NREQ); j++) set_op(j, pick(), pick(), 1'($urandom));
            if (i == 10) req_valid = '0;
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] got, exp;
        for (int i = 0; i < 300; i++) begin
            req_valid = (i >= 296) ? '0 : NREQ'($urandom);
            for (int j = 0; j < int'(NREQ); j++) set_op(j, pick(), pick(), 1'($urandom));
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc %0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [CW-1:0] got, exp;
        set_op(0, 24'h123456, 24'h000111, 1'b0);
        req_valid = 4'b0001;
        step(got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rst_mid_first: got %h exp %h", got, exp);
        end
        set_op(1, 24'h000010, 24'h000020, 1'b1);
        req_valid = 4'b0010;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: got %b_%b exp 0000_0000", req_ready, rsp_valid);
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step(got, exp);
            checks++;
            if (got !== exp || rsp_valid !== '0) begin
                errors++;
                $display("FAIL rst_mid_quiet cyc %0d: got %h exp %h", c, got, exp);
            end
        end
        set_op(3, 24'h000002, 24'h000003, 1'b0);
        req_valid = 4'b1000;
        step(got, exp);
        checks++;
        if (got !== exp || got[CW-1 -: NREQ] !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid_lone3: got %h exp %h", got, exp);
        end
        req_valid = '1;
        step(got, exp);
        checks++;
        if (got !== exp || got[CW-1 -: NREQ] !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_ptr0: got %h exp %h", got, exp);
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_drain cyc %0d: got %h exp %h", c, got, exp);
            end
        end
    endtask

`ifdef ADDER_ARB_BACKPRESSURE_EN
    task automatic test_backpressure();
        logic [DW-1:0] oa[3], ob[3], ra[3];
        logic [3:0]    fa[3];
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            oa[j] = pick();
            ob[j] = pick();
            ref_alu(oa[j], ob[j], 1'b0, ra[j], fa[j]);
        end
        rsp_ready    = '1;
        rsp_ready[1] = 1'b0;
        req_valid    = 4'b0010;
        for (int j = 0; j < 2; j++) begin
            set_op(1, oa[j], ob[j], 1'b0);
            #1;
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++;
                $display("FAIL bp_accept %0d: got %b exp 0010", j, req_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        set_op(1, oa[2], ob[2], 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_r, rsp_flags} !== {4'b0000, 4'b0010, ra[0], fa[0]}) begin
                errors++;
                $display("FAIL bp_stall cyc %0d: got %b %b %h %b exp 0000 0010 %h %b", c,
                         req_ready, rsp_valid, rsp_r, rsp_flags, ra[0], fa[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release: got %b exp 0010", req_ready);
        end
        for (int j = 1; j < 3; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_r, rsp_flags} !== {4'b0010, ra[j], fa[j]}) begin
                errors++;
                $display("FAIL bp_drain %0d: got %b %h %b exp 0010 %h %b", j,
                         rsp_valid, rsp_r, rsp_flags, ra[j], fa[j]);
            end
            @(negedge clk);
            req_valid = '0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL bp_empty: got %b exp 0000", rsp_valid);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        edge_cnt  = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
`ifdef ADDER_ARB_BACKPRESSURE_EN
        rsp_ready = '1;
`endif
        model_reset();
        test_reset();
        test_arith();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ADDER_ARB_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
